// File: rtl/ps2_rx_control_pkg.sv
// Shared definitions for the PS/2 receive controller: FSM state encoding,
// default filter/timeout parameters and the PS/2 frame length.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERR   = 2'd3
    } rx_state_e;

    localparam int unsigned FILTER_LEN_DEF = 8;
    localparam int unsigned TIMEOUT_DEF    = 100000;
    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS     = 11;

endpackage

// File: rtl/ps2_rx_control_if.sv
// Strobe/flag bundle between the PS/2 receive controller and the scan-code
// shift datapath.
//   master (controller): drives Load, Borrar, New, DataSync;
//                        reads EndTras, ParityCoherente.
//   slave  (datapath)  : the reverse.
interface ps2_rx_control_if;

    logic Load;
    logic Borrar;
    logic New;
    logic DataSync;
    logic EndTras;
    logic ParityCoherente;

    modport master (
        output Load, Borrar, New, DataSync,
        input  EndTras, ParityCoherente
    );

    modport slave (
        input  Load, Borrar, New, DataSync,
        output EndTras, ParityCoherente
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 keyboard clock conditioning: 2-flop synchronizer, glitch filter and a
// registered one-cycle falling-edge strobe.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   kb_clk_i : raw asynchronous PS/2 clock pin
//   fall_o   : one-cycle strobe after the filtered clock goes high->low
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic kb_clk_i,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    // Filter: count consecutive samples that disagree with the filtered
    // level; flip the level once the count reaches FILTER_LEN.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], kb_clk_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_control.sv
// PS/2 receive controller. Sequences the scan-code shift datapath (Load,
// Borrar, New), checks frame completion/parity and recovers from stalled
// frames by timeout.
//   Clk, Reset      : system clock, synchronous active-high reset
//   ClkKB, DataKB   : raw asynchronous PS/2 pins
//   dp              : datapath strobes/flags (master side)
//   FrameError      : one-cycle strobe on bad parity/framing or timeout
//   Busy            : high while a frame is being received
module ps2_rx_control
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClkKB,
    input  logic              DataKB,
    ps2_rx_control_if.master  dp,
    output logic              FrameError,
    output logic              Busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT);

    rx_state_e       state_q, state_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]      data_sync_q;
    logic            fall;
    logic            load_c, borrar_c, new_c, fe_c, busy_c;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .kb_clk_i (ClkKB),
        .fall_o   (fall)
    );

    // Data pin synchronizer; PS/2 data is stable far longer than the clock
    // filter delay, so no further alignment is needed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_sync_q <= 2'b00;
        end else begin
            data_sync_q <= {data_sync_q[0], DataKB};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d  = state_q;
        tcnt_d   = '0;
        load_c   = 1'b0;
        borrar_c = 1'b0;
        new_c    = 1'b0;
        fe_c     = 1'b0;
        busy_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                borrar_c = ~fall;
                if (fall) begin
                    load_c  = 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                busy_c = 1'b1;
                load_c = fall;
                if (!fall) begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
                // Compare the incremented count so ERR lands exactly
                // TIMEOUT cycles after the last fall.
                if (dp.EndTras) begin
                    state_d = ST_CHECK;
                end else if (!fall && tcnt_d == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHECK: begin
                new_c   = dp.ParityCoherente;
                fe_c    = ~dp.ParityCoherente;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                fe_c     = 1'b1;
                borrar_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold the datapath cleared and quiet while reset is asserted,
        // including the cycle before the state register takes it.
        if (Reset) begin
            load_c   = 1'b0;
            new_c    = 1'b0;
            fe_c     = 1'b0;
            busy_c   = 1'b0;
            borrar_c = 1'b1;
        end
    end

    assign dp.Load     = load_c;
    assign dp.Borrar   = borrar_c;
    assign dp.New      = new_c;
    assign dp.DataSync = data_sync_q[1];
    assign FrameError  = fe_c;
    assign Busy        = busy_c;

endmodule

// File: doc/ps2_rx_control.md
# ps2_rx_control

Receive controller for the PS/2 keyboard port. It conditions the raw keyboard clock, detects falling edges, and sequences the scan-code shift datapath through that datapath's load, clear and new-code strobes. It also checks frame completion and parity, and recovers from truncated or corrupt frames by timeout. It sits between the keyboard pins and the scan-code datapath, whose `EndTras` and `ParityCoherente` outputs it consumes.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronized samples required before the filtered keyboard clock changes level.
- `TIMEOUT`, 100000: maximum cycles between falling edges inside a frame (2 ms at 50 MHz).
- `Clk` in 1: system clock; the only clock.
- `Reset` in 1: synchronous, active-high reset.
- `ClkKB` in 1: raw PS/2 clock pin, asynchronous.
- `DataKB` in 1: raw PS/2 data pin, asynchronous.
- `EndTras` in 1: datapath frame-complete flag; high after 11 loads.
- `ParityCoherente` in 1: datapath start/stop/odd-parity check, combinational from the shift register.
- `Load` out 1: shift one bit into the datapath.
- `Borrar` out 1: clear the datapath bit counter.
- `New` out 1: one-cycle strobe; the datapath registers `NewScanCode` on the following cycle.
- `DataSync` out 1: `DataKB` after 2 flops; wired to the datapath's data input.
- `FrameError` out 1: one-cycle strobe on a parity/framing failure or timeout.
- `Busy` out 1: high while a frame is in progress.

## Operation
- **Synchronizer:** `ClkKB` and `DataKB` each pass through 2 flops.
- **Glitch filter:** a counter runs while the synchronized clock differs from the filtered level. It clears when they agree. When it reaches `FILTER_LEN`, the filtered level flips and the counter clears. A high→low flip produces the registered one-cycle strobe `fall`.
- **States:** IDLE, RECV, CHECK, ERR.
- **IDLE:** `Borrar`=1 except in a cycle where `fall`=1. On `fall`: `Load`=1, `Borrar`=0, go to RECV (the start bit is captured).
- **RECV:** `Load`=`fall`, `Borrar`=0, `Busy`=1.
  - The timeout counter clears on `fall` and increments otherwise.
  - `EndTras`=1 → CHECK. This takes priority over timeout.
  - Counter = `TIMEOUT`-1 with no `fall` → ERR.
- **CHECK:** lasts one cycle.
  - `New`=`ParityCoherente`, `FrameError`=!`ParityCoherente`, `Borrar`=0.
  - Next state is IDLE. A `fall` in this cycle is ignored.
- **ERR:** lasts one cycle. `FrameError`=1, `Borrar`=1, next state IDLE.
- **Output decoding:** outputs are combinational from state, `fall`, timeout and the datapath inputs. No output pulses for more than one cycle, except `Borrar`/`Busy`.
- **`Load` vs `Borrar`:** they are never both high.
- **Reset values:** state IDLE, filtered level 1, counters 0, `fall`=0. This gives `Load`=0, `New`=0, `FrameError`=0, `Busy`=0, `Borrar`=1, `DataSync`=0.
- **Reset mid-frame:** abandons the frame. `Borrar` holds the datapath counter cleared.

## Timing
- `ClkKB` falling at the pin → `Load`: 2 sync cycles + `FILTER_LEN` cycles + 1 cycle (`fall` register).
- **Data alignment:** `DataSync` is sampled by the datapath at `Load`. PS/2 data is stable ≥5 µs around the clock edge, far longer than the filter delay, so no extra data alignment is applied.
- **Frame end:** 11th `Load` → `EndTras` high next cycle → CHECK → `New` in that cycle → datapath `NewScanCode` one cycle later.
- **Timeout:** ERR is entered exactly `TIMEOUT` cycles after the last `fall` in RECV.
- **Frame spacing:** minimum 1 IDLE cycle between frames; back-to-back frames are accepted.

## Structure
- **Shared package `ps2_pkg`:** state enum (IDLE, RECV, CHECK, ERR), default `FILTER_LEN`/`TIMEOUT`, frame length constant 11.
- **Sub-module `ps2_clk_filter`:** clock synchronizer, glitch filter and `fall` strobe. The data synchronizer stays in the top level.
- **Counter widths:** `$clog2(TIMEOUT)` for the timeout counter, `$clog2(FILTER_LEN+1)` for the filter counter.

## Test plan
- **Good frame:** scan code 0x1C sent as frame bits 0,0,0,1,1,1,0,0,0,0(parity),1 at a 12.5 kHz keyboard clock → exactly 11 `Load`s. `New` pulses once; datapath `ScanCode`=0x1C; `FrameError` stays 0.
- **Bad parity:** 0x1C with the parity bit flipped to 1 → `New` stays 0; one `FrameError` pulse in CHECK; back in IDLE with `Borrar`=1.
- **Glitch rejection:** a `ClkKB` low pulse of `FILTER_LEN`-2 cycles during IDLE and during RECV → no `Load`. A pulse of `FILTER_LEN`+3 cycles → one `Load`.
- **Timeout:** stop the keyboard clock after 5 bits → `FrameError` exactly `TIMEOUT` cycles after the last `fall`, then IDLE. A following 0xF0 frame → `New` with `ScanCode`=0xF0.
- **Reset mid-frame:** `Reset` for 1 cycle after bit 6 → IDLE; `Borrar`=1 during and after reset. The next full 0x1C frame is received correctly.
- **Back-to-back:** frames 0xE0 and 0x75 with a 60 µs gap → two `New` pulses, no `FrameError`.
